// File: rtl/sd_wb_pkg.sv
// Shared Wishbone cycle-type / burst-type constants and the slave FSM
// state encoding for the SD DMA test memory.
package sd_wb_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        ERR  = 2'd2
    } wb_state_t;

endpackage

// File: rtl/sd_dma_wb_ram.sv
// Word-organised RAM with combinational read and per-byte write enables.
// Contents are deliberately not reset.
module sd_dma_wb_ram #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data,
    input  logic [3:0]    wr_be
);

    logic [31:0] mem [2**AW];

    assign rd_data = mem[rd_addr];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) begin
                mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/sd_dma_wb_mem.sv
// Wishbone B3 slave memory for the SD controller DMA port: classic and
// linear incrementing bursts, patterned ack stalls, per-direction beat counts.
module sd_dma_wb_mem
    import sd_wb_pkg::*;
#(
    parameter int         AW        = 8,
    parameter bit         BYTE_ADR  = 1'b1,
    parameter logic [7:0] STALL_PAT = 8'b0101_1010
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic [2:0]  wb_cti_i,
    input  logic [1:0]  wb_bte_i,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    input  logic        stall_en_i,
    output logic [15:0] wr_cnt_o,
    output logic [15:0] rd_cnt_o
);

    wb_state_t     state;
    wb_state_t     state_nxt;
    logic [2:0]    ptr;
    logic [2:0]    ptr_nxt;
    logic          permit;
    logic          req;
    logic          burst_ok;
    logic          bad;
    logic          out_of_range;
    logic [AW-1:0] idx;
    logic [AW-1:0] cur_idx;
    logic [AW-1:0] rd_idx;
    logic [31:0]   ram_rdata;
    logic [31:0]   dat_r;
    logic [15:0]   wr_cnt;
    logic [15:0]   rd_cnt;
    logic          ack_vis;
    logic          err_vis;
    logic          load_beat;
    logic [3:0]    wr_be;

    generate
        if (BYTE_ADR) begin : g_byte_adr
            logic adr_lsb_unused;
            assign adr_lsb_unused = ^wb_adr_i[1:0];
            assign idx            = wb_adr_i[AW+1:2];
            assign out_of_range   = |wb_adr_i[31:AW+2];
        end else begin : g_word_adr
            assign idx          = wb_adr_i[AW-1:0];
            assign out_of_range = |wb_adr_i[31:AW];
        end
    endgenerate

    // Acks are registered, so the slot that gates a decision taken now is the
    // one the pointer will hold when the ack actually becomes visible.
    assign ptr_nxt  = ptr + 3'd1;
    assign permit   = !stall_en_i || STALL_PAT[ptr_nxt];
    assign req      = wb_cyc_i && wb_stb_i;
    assign burst_ok = (wb_cti_i == CTI_INCR) && (wb_bte_i == BTE_LINEAR);
    assign bad      = out_of_range || ((wb_cti_i == CTI_INCR) && (wb_bte_i != BTE_LINEAR));
    assign rd_idx   = (state == ACK) ? cur_idx + AW'(1) : idx;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (req && bad) begin
                    state_nxt = ERR;
                end else if (req && permit) begin
                    state_nxt = ACK;
                end
            end
            ACK: begin
                if (req && burst_ok && permit) begin
                    state_nxt = ACK;
                end else begin
                    state_nxt = IDLE;
                end
            end
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ack_vis   = 1'b0;
        err_vis   = 1'b0;
        load_beat = (state_nxt == ACK);
        unique case (state)
            ACK:     ack_vis = req;
            ERR:     err_vis = req;
            default: ;
        endcase
    end

    assign wr_be = (ack_vis && wb_we_i) ? wb_sel_i : 4'b0000;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            ptr     <= 3'd0;
            cur_idx <= '0;
            dat_r   <= 32'd0;
            wr_cnt  <= 16'd0;
            rd_cnt  <= 16'd0;
        end else begin
            ptr <= ptr_nxt;
            if (load_beat) begin
                cur_idx <= rd_idx;
                if (!wb_we_i) begin
                    dat_r <= ram_rdata;
                end
            end
            if (ack_vis && wb_we_i && (wr_cnt != 16'hFFFF)) begin
                wr_cnt <= wr_cnt + 16'd1;
            end
            if (ack_vis && !wb_we_i && (rd_cnt != 16'hFFFF)) begin
                rd_cnt <= rd_cnt + 16'd1;
            end
        end
    end

    sd_dma_wb_ram #(.AW(AW)) u_ram (
        .clk     (wb_clk_i),
        .rd_addr (rd_idx),
        .rd_data (ram_rdata),
        .wr_addr (cur_idx),
        .wr_data (wb_dat_i),
        .wr_be   (wr_be)
    );

    assign wb_ack_o = ack_vis;
    assign wb_err_o = err_vis;
    assign wb_dat_o = dat_r;
    assign wr_cnt_o = wr_cnt;
    assign rd_cnt_o = rd_cnt;

endmodule

// File: tb/tb_sd_dma_wb_mem.sv
// Scoreboard bench for sd_dma_wb_mem: a Wishbone master queues the expected
// response of every beat, a negedge monitor pops and compares each ack/err.
module tb_sd_dma_wb_mem;
    import sd_wb_pkg::*;

    localparam logic [7:0] PAT = 8'b0101_1010;

    typedef struct {
        logic        err;
        logic        rd;
        logic [31:0] dat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] adr = 32'd0;
    logic [31:0] dat_w = 32'd0;
    logic [31:0] dat_r;
    logic [3:0]  sel = 4'h0;
    logic        we = 1'b0;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic [2:0]  cti = 3'b000;
    logic [1:0]  bte = 2'b00;
    logic        ack;
    logic        err;
    logic        stall_en = 1'b0;
    logic [15:0] wr_cnt;
    logic [15:0] rd_cnt;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          acks_seen = 0;
    int          ack_mark;
    logic [2:0]  tb_ptr;

    sd_dma_wb_mem #(.AW(8), .BYTE_ADR(1'b1), .STALL_PAT(PAT)) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .wb_adr_i   (adr),
        .wb_dat_i   (dat_w),
        .wb_dat_o   (dat_r),
        .wb_sel_i   (sel),
        .wb_we_i    (we),
        .wb_cyc_i   (cyc),
        .wb_stb_i   (stb),
        .wb_cti_i   (cti),
        .wb_bte_i   (bte),
        .wb_ack_o   (ack),
        .wb_err_o   (err),
        .stall_en_i (stall_en),
        .wr_cnt_o   (wr_cnt),
        .rd_cnt_o   (rd_cnt)
    );

    always #5 clk = ~clk;

    // Free-running slot counter: zero out of reset, one step per clock.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_ptr <= 3'd0;
        else        tb_ptr <= tb_ptr + 3'd1;
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && (ack || err)) begin
            if (ack) acks_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_response: got ack=%0b err=%0b, expected none", ack, err);
            end else begin
                mon_e = exp_q.pop_front();
                check_output("resp_is_err", {31'd0, err}, {31'd0, mon_e.err});
                if (ack && mon_e.rd) check_output("read_data", dat_r, mon_e.dat);
            end
            if (ack && stall_en) check_output("ack_in_stall_slot", {31'd0, PAT[tb_ptr]}, 32'd1);
        end
    end

    task automatic apply_stimulus(input logic [31:0] a, input logic w, input logic [31:0] d,
                                  input logic [3:0] s, input logic [2:0] c, input logic [1:0] b,
                                  input logic exp_err, input logic [31:0] exp_dat);
        exp_t e;
        bit   got;
        e.err = exp_err;
        e.rd  = !w;
        e.dat = exp_dat;
        exp_q.push_back(e);
        adr = a; we = w; dat_w = d; sel = s; cti = c; bte = b;
        cyc = 1'b1; stb = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            if (ack || err) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("[TB] FAIL beat_timeout: got no response at adr %h, expected ack or err", a);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic end_cycle();
        cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = CTI_CLASSIC; bte = BTE_LINEAR;
        @(posedge clk);
        #1;
    endtask

    task automatic wr_word(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        apply_stimulus(a, 1'b1, d, s, CTI_CLASSIC, BTE_LINEAR, 1'b0, 32'd0);
        end_cycle();
    endtask

    task automatic rd_word(input logic [31:0] a, input logic [31:0] d);
        apply_stimulus(a, 1'b0, 32'd0, 4'hF, CTI_CLASSIC, BTE_LINEAR, 1'b0, d);
        end_cycle();
    endtask

    function automatic logic [31:0] prep_word(input int i);
        return 32'hC0DE_0000 + 32'(i);
    endfunction

    initial begin
        #1_000_000;
        $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_ack", {31'd0, ack}, 32'd0);
        check_output("reset_err", {31'd0, err}, 32'd0);
        check_output("reset_dat", dat_r, 32'd0);
        check_output("reset_wr_cnt", {16'd0, wr_cnt}, 32'd0);
        check_output("reset_rd_cnt", {16'd0, rd_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Classic write then read back
        wr_word(32'h10, 32'hA5A5_1234, 4'hF);
        rd_word(32'h10, 32'hA5A5_1234);
        check_output("t1_wr_cnt", {16'd0, wr_cnt}, 32'd1);
        check_output("t1_rd_cnt", {16'd0, rd_cnt}, 32'd1);

        // Byte-lane write and empty-select write
        wr_word(32'h20, 32'h0000_0000, 4'hF);
        wr_word(32'h20, 32'hFFFF_FFFF, 4'b0010);
        rd_word(32'h20, 32'h0000_FF00);
        wr_word(32'h20, 32'h1234_5678, 4'b0000);
        rd_word(32'h20, 32'h0000_FF00);
        check_output("t2_wr_cnt", {16'd0, wr_cnt}, 32'd4);
        check_output("t2_rd_cnt", {16'd0, rd_cnt}, 32'd3);

        // Fill words 0..7 with a full-rate write burst
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(32'(4 * i), 1'b1, prep_word(i), 4'hF,
                           (i < 7) ? CTI_INCR : CTI_EOB, BTE_LINEAR, 1'b0, 32'd0);
        end
        end_cycle();
        check_output("prep_wr_cnt", {16'd0, wr_cnt}, 32'd12);

        // Stalled read burst of 8 beats
        stall_en = 1'b1;
        ack_mark = acks_seen;
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(32'(4 * i), 1'b0, 32'd0, 4'hF,
                           (i < 7) ? CTI_INCR : CTI_EOB, BTE_LINEAR, 1'b0, prep_word(i));
        end
        end_cycle();
        repeat (4) @(posedge clk);
        #1;
        check_output("t3_burst_acks", 32'(acks_seen - ack_mark), 32'd8);
        check_output("t3_rd_cnt", {16'd0, rd_cnt}, 32'd11);
        stall_en = 1'b0;

        // Out-of-range accesses terminate with a single-cycle error
        apply_stimulus(32'h0000_0400, 1'b0, 32'd0, 4'hF, CTI_CLASSIC, BTE_LINEAR, 1'b1, 32'd0);
        check_output("t4_err_one_cycle", {31'd0, err}, 32'd0);
        check_output("t4_no_ack", {31'd0, ack}, 32'd0);
        end_cycle();
        apply_stimulus(32'h0000_0400, 1'b1, 32'hDEAD_BEEF, 4'hF, CTI_CLASSIC, BTE_LINEAR, 1'b1, 32'd0);
        end_cycle();
        check_output("t4_wr_cnt", {16'd0, wr_cnt}, 32'd12);
        check_output("t4_rd_cnt", {16'd0, rd_cnt}, 32'd11);

        // Unsupported burst type, then an abandoned write burst
        apply_stimulus(32'h0, 1'b0, 32'd0, 4'hF, CTI_INCR, 2'b01, 1'b1, 32'd0);
        end_cycle();
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(32'(4 * i), 1'b1, 32'hBEEF_0000 + 32'(i), 4'hF,
                           CTI_INCR, BTE_LINEAR, 1'b0, 32'd0);
        end
        end_cycle();
        check_output("t5_wr_cnt", {16'd0, wr_cnt}, 32'd15);
        for (int i = 0; i < 8; i++) begin
            rd_word(32'(4 * i), (i < 3) ? 32'hBEEF_0000 + 32'(i) : prep_word(i));
        end
        check_output("t5_rd_cnt", {16'd0, rd_cnt}, 32'd19);

        // Reset in the middle of a read burst
        apply_stimulus(32'h0, 1'b0, 32'd0, 4'hF, CTI_INCR, BTE_LINEAR, 1'b0, 32'hBEEF_0000);
        apply_stimulus(32'h4, 1'b0, 32'd0, 4'hF, CTI_INCR, BTE_LINEAR, 1'b0, 32'hBEEF_0001);
        adr = 32'h8;
        rst_n = 1'b0;
        #1;
        check_output("t6_ack_cleared", {31'd0, ack}, 32'd0);
        check_output("t6_err_cleared", {31'd0, err}, 32'd0);
        check_output("t6_dat_cleared", dat_r, 32'd0);
        check_output("t6_wr_cnt_cleared", {16'd0, wr_cnt}, 32'd0);
        check_output("t6_rd_cnt_cleared", {16'd0, rd_cnt}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        cyc = 1'b0; stb = 1'b0; cti = CTI_CLASSIC;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        rd_word(32'h0, 32'hBEEF_0000);
        rd_word(32'h14, prep_word(5));
        check_output("t6_rd_cnt_after", {16'd0, rd_cnt}, 32'd2);
        check_output("t6_wr_cnt_after", {16'd0, wr_cnt}, 32'd0);

        repeat (3) @(posedge clk);
        #1;
        check_output("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
